// File: rtl/trdb_stream_unalign8.sv
// trdb_stream_unalign8
// Recovers length-prefixed, bit-packed packets from a byte-packed 32-bit
// stream. Each packet starts on a byte boundary with a PACKET_HEADER_LEN-bit
// length field L, followed immediately by L payload bits. Zero bytes between
// packets are padding. Incoming words are visible to the parser in the cycle
// they are accepted, so a packet completed by a word is emitted one cycle later.
module trdb_stream_unalign8 #(
    parameter int unsigned PACKET_HEADER_LEN = 7,
    parameter int unsigned PACKET_LEN        = 128
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [31:0]                  data_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic                         flush_i,
    output logic                         flush_confirm_o,
    output logic [PACKET_LEN-1:0]        packet_bits_o,
    output logic [PACKET_HEADER_LEN-1:0] packet_len_o,
    output logic                         valid_o,
    input  logic                         ready_i
);

    // Largest packet in bytes plus room for one word and a partial tail.
    localparam int unsigned BUF_BYTES = (PACKET_HEADER_LEN + PACKET_LEN + 7) / 8 + 7;
    localparam int unsigned BUF_BITS  = 8 * BUF_BYTES;
    localparam int unsigned FILL_W    = $clog2(BUF_BYTES + 1);
    // Byte counts (fill + 4, packet size) are handled at a width that cannot overflow.
    localparam int unsigned CNT_W     = FILL_W + PACKET_HEADER_LEN;

    // What the parser does with the oldest byte this cycle.
    typedef enum logic [1:0] {
        ACT_NONE,
        ACT_PAD,
        ACT_PKT
    } action_e;

    // Byte FIFO: byte i lives at bits [8*i +: 8], byte 0 is the oldest.
    logic [BUF_BITS-1:0]          buf_q;
    logic [BUF_BITS-1:0]          buf_d;
    logic [FILL_W-1:0]            fill_q;
    logic [FILL_W-1:0]            fill_d;

    // Buffer contents plus the word being accepted this cycle.
    logic [BUF_BITS-1:0]          view;
    logic [CNT_W-1:0]             avail;
    logic                         push;

    // Parser results.
    logic [PACKET_HEADER_LEN-1:0] hdr_len;
    logic [CNT_W-1:0]             pkt_bytes;
    logic [CNT_W-1:0]             pop_cnt;
    action_e                      action;
    logic [PACKET_LEN-1:0]        payload_mask;
    logic [PACKET_LEN-1:0]        payload;

    // Output register.
    logic [PACKET_LEN-1:0]        bits_q;
    logic [PACKET_HEADER_LEN-1:0] len_q;
    logic                         valid_q;
    logic                         flush_confirm_q;

    // Accept a word only while a whole word still fits after this cycle's
    // worst case (no pop); independent of downstream handshake.
    assign ready_o = !flush_i && (fill_q <= FILL_W'(BUF_BYTES - 4));
    assign push    = valid_i && ready_o;

    // Merge the accepted word behind the buffered bytes.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path infers a latch.
        view  = buf_q;
        avail = CNT_W'(fill_q);
        if (push) begin
            view  = buf_q | (BUF_BITS'(data_i) << {fill_q, 3'b000});
            avail = CNT_W'(fill_q) + CNT_W'(4);
        end
    end

    // Header of the oldest packet and its total size in bytes (header included).
    assign hdr_len   = view[PACKET_HEADER_LEN-1:0];
    assign pkt_bytes = (CNT_W'(hdr_len) + CNT_W'(PACKET_HEADER_LEN + 7)) >> 3;

    // Decide between padding drop, packet extraction or waiting.
    always_comb begin
        action  = ACT_NONE;
        pop_cnt = '0;
        if (!flush_i && (avail != '0)) begin
            if (view[7:0] == 8'h00) begin
                action  = ACT_PAD;
                pop_cnt = CNT_W'(1);
            end else if ((avail >= pkt_bytes) && (!valid_q || ready_i)) begin
                action  = ACT_PKT;
                pop_cnt = pkt_bytes;
            end
        end
    end

    // Payload sits right after the header; bits beyond L are forced to zero.
    always_comb begin
        for (int i = 0; i < PACKET_LEN; i++) begin
            payload_mask[i] = (i < int'(hdr_len));
        end
        payload = PACKET_LEN'(view >> PACKET_HEADER_LEN) & payload_mask;
    end

    // Next buffer state: drop popped bytes from the front, or empty on flush.
    always_comb begin
        buf_d  = view >> {pop_cnt, 3'b000};
        fill_d = FILL_W'(avail - pop_cnt);
        if (flush_i) begin
            buf_d  = '0;
            fill_d = '0;
        end
    end

    // Byte buffer and fill counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: the buffer is reset on purpose; the merge above ORs the new word
            // in, which relies on every byte at or above fill being zero.
            buf_q  <= '0;
            fill_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            buf_q  <= buf_d;
            fill_q <= fill_d;
        end
    end

    // Output register: load on extraction, clear valid once consumed, else hold.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bits_q  <= '0;
            len_q   <= '0;
            valid_q <= 1'b0;
        end else if (action == ACT_PKT) begin
            bits_q  <= payload;
            len_q   <= hdr_len;
            valid_q <= 1'b1;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    // Flush completes in one cycle; acknowledge on the following cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            flush_confirm_q <= 1'b0;
        end else begin
            flush_confirm_q <= flush_i;
        end
    end

    assign packet_bits_o   = bits_q;
    assign packet_len_o    = len_q;
    assign valid_o         = valid_q;
    assign flush_confirm_o = flush_confirm_q;

endmodule

// File: tb/tb_trdb_stream_unalign8.sv
// tb_trdb_stream_unalign8
// Directed scenarios for latency, back-pressure, flush, maximum packet and
// asynchronous reset, followed by a randomized stream whose expected packets
// are built directly from the length-prefix packing rules.
module tb_trdb_stream_unalign8;

    localparam int unsigned HL = 7;
    localparam int unsigned PL = 128;

    typedef struct packed {
        logic [HL-1:0] len;
        logic [PL-1:0] bits;
    } pkt_t;

    logic          clk_i;
    logic          rst_i;
    logic [31:0]   data_i;
    logic          valid_i;
    logic          ready_o;
    logic          flush_i;
    logic          flush_confirm_o;
    logic [PL-1:0] packet_bits_o;
    logic [HL-1:0] packet_len_o;
    logic          valid_o;
    logic          ready_i;

    int   n_cmp = 0;
    int   n_err = 0;
    logic mon_en;
    pkt_t got_q[$];
    pkt_t exp_q[$];

    trdb_stream_unalign8 #(
        .PACKET_HEADER_LEN(HL),
        .PACKET_LEN       (PL)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .data_i         (data_i),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .flush_i        (flush_i),
        .flush_confirm_o(flush_confirm_o),
        .packet_bits_o  (packet_bits_o),
        .packet_len_o   (packet_len_o),
        .valid_o        (valid_o),
        .ready_i        (ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Record every packet handed over downstream (sampled mid-cycle).
    always @(negedge clk_i) begin
        if (mon_en && !rst_i && valid_o && ready_i) begin
            got_q.push_back({packet_len_o, packet_bits_o});
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            n_acc;
        int            word_idx;
        int            cycles;
        logic          accepted;
        int unsigned   len_r;
        int unsigned   nbytes;
        int unsigned   npad;
        logic [127:0]  pay;
        logic [127:0]  pmask;
        logic [135:0]  pkt;
        logic [135:0]  junk;
        logic [135:0]  jmask;
        logic [7:0]    stream_q[$];
        logic [31:0]   words[$];

        rst_i   = 1'b1;
        valid_i = 1'b0;
        data_i  = '0;
        flush_i = 1'b0;
        ready_i = 1'b1;
        mon_en  = 1'b0;

        // Reset state
        #12;
        check("rst_valid", 256'(valid_o), 256'(0));
        check("rst_bits", 256'(packet_bits_o), 256'(0));
        check("rst_len", 256'(packet_len_o), 256'(0));
        check("rst_flush_confirm", 256'(flush_confirm_o), 256'(0));
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check("rst_ready", 256'(ready_o), 256'(1));
        tick();

        // Single 9-bit packet followed by two padding bytes
        data_i  = 32'h0000_D289;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        check("p9_valid", 256'(valid_o), 256'(1));
        check("p9_len", 256'(packet_len_o), 256'(9));
        check("p9_bits", 256'(packet_bits_o), 256'(128'h1A5));
        tick();
        check("p9_pad1_quiet", 256'(valid_o), 256'(0));
        tick();
        check("p9_pad2_quiet", 256'(valid_o), 256'(0));
        check("p9_ready", 256'(ready_o), 256'(1));
        tick();

        // 57-bit packet spanning three words
        data_i  = 32'hFFB9_0000;
        valid_i = 1'b1;
        tick();
        check("p57_w1_none", 256'(valid_o), 256'(0));
        data_i = 32'hFFFF_FFFF;
        tick();
        check("p57_w2_none", 256'(valid_o), 256'(0));
        data_i = 32'h0000_FFFF;
        tick();
        valid_i = 1'b0;
        check("p57_valid", 256'(valid_o), 256'(1));
        check("p57_len", 256'(packet_len_o), 256'(57));
        check("p57_bits", 256'(packet_bits_o), 256'((128'(1) << 57) - 128'(1)));
        tick();
        check("p57_once", 256'(valid_o), 256'(0));
        tick();
        tick();

        // Back-pressure: downstream stalled while words keep arriving
        ready_i = 1'b0;
        data_i  = 32'hD289_D289;
        n_acc   = 0;
        for (int c = 0; c < 8; c++) begin
            valid_i = 1'b1;
            if (ready_o) n_acc++;
            tick();
            check("bp_hold_valid", 256'(valid_o), 256'(1));
            check("bp_hold_bits", 256'({packet_len_o, packet_bits_o}), 256'({7'd9, 128'h1A5}));
        end
        valid_i = 1'b0;
        check("bp_words_accepted", 256'(n_acc), 256'(6));
        check("bp_ready_low", 256'(ready_o), 256'(0));
        got_q.delete();
        mon_en  = 1'b1;
        ready_i = 1'b1;
        repeat (20) tick();
        mon_en = 1'b0;
        check("bp_count", 256'(got_q.size()), 256'(12));
        for (int k = 0; k < got_q.size(); k++) begin
            check("bp_pkt", 256'(got_q[k]), 256'({7'd9, 128'h1A5}));
        end

        // Flush drops a partial packet
        data_i  = 32'hFFB9_0000;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        flush_i = 1'b1;
        #1;
        check("flush_ready_low", 256'(ready_o), 256'(0));
        tick();
        flush_i = 1'b0;
        check("flush_confirm_hi", 256'(flush_confirm_o), 256'(1));
        check("flush_no_out", 256'(valid_o), 256'(0));
        tick();
        check("flush_confirm_lo", 256'(flush_confirm_o), 256'(0));
        check("flush_no_out2", 256'(valid_o), 256'(0));
        data_i  = 32'h0000_D289;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        check("post_flush_valid", 256'(valid_o), 256'(1));
        check("post_flush_pkt", 256'({packet_len_o, packet_bits_o}), 256'({7'd9, 128'h1A5}));
        repeat (3) tick();

        // Maximum packet: L = 127, all-ones payload, 17 bytes
        data_i  = 32'hFFFF_FFFF;
        valid_i = 1'b1;
        for (int w = 0; w < 4; w++) begin
            tick();
            check("max_wait", 256'(valid_o), 256'(0));
        end
        data_i = 32'h0000_00FF;
        tick();
        valid_i = 1'b0;
        check("max_valid", 256'(valid_o), 256'(1));
        check("max_len", 256'(packet_len_o), 256'(127));
        check("max_bits", 256'(packet_bits_o), 256'((128'(1) << 127) - 128'(1)));
        check("max_bit127", 256'(packet_bits_o[127]), 256'(0));
        repeat (5) tick();

        // Asynchronous reset with a packet parked and a partial one buffered
        ready_i = 1'b0;
        data_i  = 32'h0000_D289;
        valid_i = 1'b1;
        tick();
        data_i = 32'hFFB9_0000;
        tick();
        valid_i = 1'b0;
        check("arst_pre_valid", 256'(valid_o), 256'(1));
        #2;
        rst_i = 1'b1;
        #1;
        check("arst_valid", 256'(valid_o), 256'(0));
        check("arst_len", 256'(packet_len_o), 256'(0));
        check("arst_bits", 256'(packet_bits_o), 256'(0));
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check("arst_ready", 256'(ready_o), 256'(1));
        ready_i = 1'b1;
        data_i  = 32'h0000_D289;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        check("arst_after_valid", 256'(valid_o), 256'(1));
        check("arst_after_pkt", 256'({packet_len_o, packet_bits_o}), 256'({7'd9, 128'h1A5}));
        repeat (3) tick();

        // Randomized stream: random lengths, payloads, tail bits and padding
        got_q.delete();
        exp_q.delete();
        for (int p = 0; p < 40; p++) begin
            npad = $urandom_range(0, 3);
            for (int z = 0; z < int'(npad); z++) stream_q.push_back(8'h00);
            len_r  = $urandom_range(0, 127);
            pay    = {$urandom, $urandom, $urandom, $urandom};
            pmask  = (128'(1) << len_r) - 128'(1);
            pay    = pay & pmask;
            nbytes = (len_r + 14) / 8;
            junk   = {$urandom, $urandom, $urandom, $urandom, 8'($urandom)};
            jmask  = ((136'(1) << (8 * nbytes)) - 136'(1)) & ~((136'(1) << (len_r + 7)) - 136'(1));
            pkt    = 136'(len_r) | (136'(pay) << 7) | (junk & jmask);
            if (len_r == 0) pkt[7] = 1'b1;
            for (int b = 0; b < int'(nbytes); b++) stream_q.push_back(pkt[8*b +: 8]);
            exp_q.push_back({7'(len_r), pay});
        end
        while (stream_q.size() % 4 != 0) stream_q.push_back(8'h00);
        for (int w = 0; w < stream_q.size(); w += 4) begin
            words.push_back({stream_q[w+3], stream_q[w+2], stream_q[w+1], stream_q[w]});
        end

        mon_en   = 1'b1;
        word_idx = 0;
        cycles   = 0;
        while (word_idx < words.size() && cycles < 4000) begin
            data_i   = words[word_idx];
            valid_i  = ($urandom_range(0, 3) != 0);
            ready_i  = ($urandom_range(0, 2) != 0);
            accepted = valid_i && ready_o;
            tick();
            if (accepted) word_idx++;
            cycles++;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (60) tick();
        mon_en = 1'b0;
        check("rand_words_sent", 256'(word_idx), 256'(words.size()));
        check("rand_count", 256'(got_q.size()), 256'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            check("rand_pkt", (k < got_q.size()) ? 256'(got_q[k]) : 256'(0), 256'(exp_q[k]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
